// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache with a single-line refill FSM.
// Lookup is combinational; a miss stalls the PC until the line returns.
module icache_fetch #(
  parameter int LINES = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         flush_i,
  input  logic [31:0]  addr_i,
  output logic [31:0]  instr_o,
  output logic         pc_enable_o,
  output logic         mem_req_o,
  output logic [31:0]  mem_addr_o,
  input  logic         mem_ack_i,
  input  logic [127:0] mem_data_i,
  output logic [15:0]  miss_cnt_o
);
  localparam int IW = $clog2(LINES);
  localparam int TW = 28 - IW;

  typedef enum logic {IDLE, REQ} state_t;
  state_t state;

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tag_q  [LINES];
  logic [127:0]     data_q [LINES];

  logic [IW-1:0] idx, ridx;
  logic [TW-1:0] tag;
  logic [1:0]    word;
  logic          hit, miss, refill;
  logic          unused_ok;

  assign idx       = addr_i[4 +: IW];
  assign tag       = addr_i[31 -: TW];
  assign word      = addr_i[3:2];
  assign unused_ok = &{1'b0, addr_i[1:0]};
  // Refill target comes from the latched address, never the live PC.
  assign ridx      = mem_addr_o[4 +: IW];

  assign hit    = start_i & valid[idx] & (tag_q[idx] == tag);
  assign miss   = (state == IDLE) & start_i & ~hit;
  assign refill = (state == REQ) & mem_ack_i;

  always_comb begin
    pc_enable_o = 1'b0;
    instr_o     = '0;
    if (state == IDLE) begin
      pc_enable_o = ~miss;
      if (hit) instr_o = data_q[idx][{word, 5'b0} +: 32];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      valid      <= '0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      miss_cnt_o <= '0;
    end else begin
      case (state)
        IDLE: if (miss) begin
          state      <= REQ;
          mem_req_o  <= 1'b1;
          mem_addr_o <= {addr_i[31:4], 4'b0};
          if (miss_cnt_o != 16'hFFFF) miss_cnt_o <= miss_cnt_o + 16'd1;
        end
        REQ: if (mem_ack_i) begin
          state     <= IDLE;
          mem_req_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // Flush wins over a coincident refill: the line is written but stays invalid.
      if (flush_i)     valid       <= '0;
      else if (refill) valid[ridx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (refill) begin
      tag_q[ridx]  <= mem_addr_o[31 -: TW];
      data_q[ridx] <= mem_data_i;
    end
  end
endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: reset, refill timing, word select, eviction, flush.
module tb_icache_fetch;
  logic         clk, rst, start, flush, ack, pc_en, req;
  logic [31:0]  addr, instr, maddr;
  logic [127:0] mdata;
  logic [15:0]  cnt;
  int passes = 0, total = 0, low;

  icache_fetch #(.LINES(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush), .addr_i(addr),
    .instr_o(instr), .pc_enable_o(pc_en), .mem_req_o(req), .mem_addr_o(maddr),
    .mem_ack_i(ack), .mem_data_i(mdata), .miss_cnt_o(cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", name, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Services a pending miss; ack lands in REQ cycle ack_at. Returns stall length.
  task automatic run_miss(input logic [127:0] d, input int ack_at, output int n);
    int rq;
    n = 0; rq = 0;
    while (pc_en === 1'b0 && n < 50) begin
      n++;
      if (req === 1'b1) begin rq++; ack = (rq == ack_at); mdata = d; end
      @(posedge clk); #1; ack = 0; #1;
    end
    chk("miss_bound", n < 50, 1);
  endtask

  initial begin
    rst = 0; start = 1; flush = 0; ack = 0; mdata = '0; addr = 32'h40;
    #3;
    chk("rst_req", req, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_maddr", maddr, 0);
    chk("rst_instr", instr, 0);
    cyc(); rst = 1; #1;
    chk("rel_miss", pc_en, 0);
    run_miss({32'h4, 32'h3, 32'h2, 32'h1}, 1, low);
    chk("rel_stall", low, 2);
    chk("rel_instr", instr, 32'h1);
    chk("rel_cnt", cnt, 1);

    // fresh reset so the counter starts at zero for the cold miss
    start = 0; rst = 0; #1; rst = 1; #1;
    chk("rst2_cnt", cnt, 0);
    start = 1; addr = 32'h104; #1;
    chk("cold_detect", pc_en, 0);
    run_miss({32'hD, 32'hC, 32'hB, 32'hA}, 3, low);
    chk("cold_stall", low, 4);
    chk("cold_maddr", maddr, 32'h100);
    chk("cold_instr", instr, 32'hB);
    chk("cold_cnt", cnt, 1);
    chk("cold_req", req, 0);

    addr = 32'h100; #1; chk("ws0_pc", pc_en, 1); chk("ws0", instr, 32'hA);
    addr = 32'h108; #1; chk("ws2_pc", pc_en, 1); chk("ws2", instr, 32'hC);
    addr = 32'h10C; #1; chk("ws3_pc", pc_en, 1); chk("ws3", instr, 32'hD);
    cyc(); chk("ws_cnt", cnt, 1);

    addr = 32'h300; #1;
    chk("conf_detect", pc_en, 0);
    run_miss({32'h33, 32'h32, 32'h31, 32'h30}, 1, low);
    chk("conf_stall", low, 2);
    chk("conf_maddr", maddr, 32'h300);
    chk("conf_instr", instr, 32'h30);
    chk("conf_cnt", cnt, 2);
    addr = 32'h100; #1;
    chk("evict_miss", pc_en, 0);
    run_miss({32'hD, 32'hC, 32'hB, 32'hA}, 2, low);
    chk("evict_stall", low, 3);
    chk("evict_instr", instr, 32'hA);
    chk("evict_cnt", cnt, 3);

    // flush in IDLE: same-cycle lookup still hits, next cycle misses
    flush = 1; #1;
    chk("fl_same_pc", pc_en, 1);
    chk("fl_same_instr", instr, 32'hA);
    cyc(); flush = 0; #1;
    chk("fl_after", pc_en, 0);
    chk("fl_after_instr", instr, 0);
    cyc();
    chk("fl_req", req, 1);
    chk("fl_cnt", cnt, 4);
    ack = 1; flush = 1; mdata = {32'hD, 32'hC, 32'hB, 32'hA};
    cyc(); ack = 0; flush = 0; #1;
    chk("flack_req", req, 0);
    chk("flack_miss", pc_en, 0);
    run_miss({32'hD, 32'hC, 32'hB, 32'hA}, 1, low);
    chk("flack_instr", instr, 32'hA);
    chk("flack_cnt", cnt, 5);

    // reset in the middle of a refill, then a stray ack
    addr = 32'h600; #1;
    chk("mr_detect", pc_en, 0);
    cyc();
    chk("mr_req", req, 1);
    rst = 0; #1;
    chk("mr_req_abort", req, 0);
    chk("mr_cnt", cnt, 0);
    rst = 1; start = 0; ack = 1; mdata = {32'h63, 32'h62, 32'h61, 32'h60};
    cyc(); ack = 0; #1;
    chk("late_req", req, 0);
    chk("s0_pc", pc_en, 1);
    chk("s0_instr", instr, 0);
    cyc();
    chk("s0_cnt", cnt, 0);
    chk("s0_req", req, 0);
    start = 1; #1;
    chk("late_novalid", pc_en, 0);
    chk("late_instr", instr, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
